alu_operand_sequencer: RTL and testbench

//  - Execute-stage sequencer directly upstream/downstream of the 16-bit combinational ALU.
//  - Holds the register file and the PSR flag register. Accepts one decoded ALU instruction
//    per valid/ready handshake, drives ALU operands and opcode, and captures the ALU result.
//  - Writes the result back to the register file and latches the ALU flags into the PSR.

---
 rtl/alu_pkg.sv | 51 +++++
 rtl/regfile_2r1w.sv | 46 ++++
 rtl/alu_operand_sequencer.sv | 153 +++++++++++++++
 tb/tb_alu_operand_sequencer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ============================================================================
// Module : alu_pkg
// Brief  : Shared ALU opcode/flag definitions and sequencer state encoding.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam int DATA_W = 16;
    localparam int OP_W   = 5;
    localparam int FLAG_W = 5;

    localparam logic [OP_W-1:0] OP_ADD  = 5'd0;
    localparam logic [OP_W-1:0] OP_SUB  = 5'd1;
    localparam logic [OP_W-1:0] OP_CMP  = 5'd2;
    localparam logic [OP_W-1:0] OP_AND  = 5'd3;
    localparam logic [OP_W-1:0] OP_OR   = 5'd4;
    localparam logic [OP_W-1:0] OP_XOR  = 5'd5;
    localparam logic [OP_W-1:0] OP_NOT  = 5'd6;
    localparam logic [OP_W-1:0] OP_LSH  = 5'd7;
    localparam logic [OP_W-1:0] OP_RSH  = 5'd8;
    localparam logic [OP_W-1:0] OP_ARSH = 5'd9;

    localparam int FLAG_C = 0;
    localparam int FLAG_L = 1;
    localparam int FLAG_F = 2;
    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    function automatic logic op_is_legal(input logic [OP_W-1:0] op);
        return (op <= OP_ARSH);
    endfunction

    function automatic logic op_writes_psr(input logic [OP_W-1:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_CMP);
    endfunction

    function automatic logic op_writes_reg(input logic [OP_W-1:0] op);
        return op_is_legal(op) && (op != OP_CMP);
    endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_2r1w.sv
// ============================================================================
// Module : regfile_2r1w
// Brief  : NUM_REGS x DATA_W register file, two async reads, one async debug
//          read, one synchronous write, asynchronous active-low reset.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module regfile_2r1w #(
    parameter int DATA_W   = alu_pkg::DATA_W,
    parameter int NUM_REGS = 16,
    parameter int AW       = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [AW-1:0]     i_raddr_a,
    output logic [DATA_W-1:0] o_rdata_a,
    input  logic [AW-1:0]     i_raddr_b,
    output logic [DATA_W-1:0] o_rdata_b,
    input  logic [AW-1:0]     i_dbg_addr,
    output logic [DATA_W-1:0] o_dbg_data
);

    logic [DATA_W-1:0] r_mem [NUM_REGS];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Reads are not bypassed: a write lands in the array and is seen next cycle.
    assign o_rdata_a  = r_mem[i_raddr_a];
    assign o_rdata_b  = r_mem[i_raddr_b];
    assign o_dbg_data = r_mem[i_dbg_addr];

endmodule

`default_nettype wire

// File: rtl/alu_operand_sequencer.sv
// ============================================================================
// Module : alu_operand_sequencer
// Brief  : Execute-stage sequencer around an external combinational ALU:
//          accept, operand fetch, ALU capture, writeback and PSR update.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module alu_operand_sequencer #(
    parameter int DATA_W   = alu_pkg::DATA_W,
    parameter int NUM_REGS = 16,
    parameter int AW       = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [4:0]        req_op,
    input  logic [AW-1:0]     req_rdest,
    input  logic [AW-1:0]     req_rsrc,
    input  logic [7:0]        req_imm,
    input  logic              req_use_imm,
    input  logic              req_imm_signed,
    output logic [DATA_W-1:0] alu_rsrc,
    output logic [DATA_W-1:0] alu_rdest,
    output logic [4:0]        alu_opcode,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [4:0]        alu_flags,
    output logic              done,
    output logic              err,
    output logic [4:0]        psr,
    input  logic [AW-1:0]     dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    import alu_pkg::*;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_accept;
    logic              w_done;
    logic              w_err;
    logic              w_reg_we;
    logic              w_psr_we;

    logic [4:0]        r_op;
    logic [AW-1:0]     r_rdest_idx;
    logic [DATA_W-1:0] r_opa;
    logic [DATA_W-1:0] r_opb;
    logic [DATA_W-1:0] r_result;
    logic [4:0]        r_flags;
    logic [4:0]        r_psr;

    logic [DATA_W-1:0] w_rd_a;
    logic [DATA_W-1:0] w_rd_b;
    logic [DATA_W-1:0] w_imm_ext;

    assign w_imm_ext = {{(DATA_W-8){req_imm[7] & req_imm_signed}}, req_imm};

    regfile_2r1w #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .AW       (AW)
    ) u_regfile (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_we       (w_reg_we),
        .i_waddr    (r_rdest_idx),
        .i_wdata    (r_result),
        .i_raddr_a  (req_rdest),
        .o_rdata_a  (w_rd_a),
        .i_raddr_b  (req_rsrc),
        .o_rdata_b  (w_rd_b),
        .i_dbg_addr (dbg_addr),
        .o_dbg_data (dbg_data)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_done      = 1'b0;
        w_err       = 1'b0;
        w_reg_we    = 1'b0;
        w_psr_we    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_state_nxt = ST_WB;
            end
            ST_WB: begin
                w_done      = 1'b1;
                w_err       = !op_is_legal(r_op);
                w_reg_we    = op_writes_reg(r_op);
                w_psr_we    = op_writes_psr(r_op);
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Operands are frozen at accept, so the ALU sees a stable pair through EXEC.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_op        <= '0;
            r_rdest_idx <= '0;
            r_opa       <= '0;
            r_opb       <= '0;
            r_result    <= '0;
            r_flags     <= '0;
            r_psr       <= '0;
        end else begin
            if (w_accept) begin
                r_op        <= req_op;
                r_rdest_idx <= req_rdest;
                r_opa       <= w_rd_a;
                r_opb       <= req_use_imm ? w_imm_ext : w_rd_b;
            end
            if (r_state == ST_EXEC) begin
                r_result <= alu_out;
                r_flags  <= alu_flags;
            end
            if (w_psr_we) begin
                r_psr <= r_flags;
            end
        end
    end

    assign req_ready  = (r_state == ST_IDLE);
    assign alu_rdest  = r_opa;
    assign alu_rsrc   = r_opb;
    assign alu_opcode = r_op;
    assign done       = w_done;
    assign err        = w_err;
    assign psr        = r_psr;

endmodule

`default_nettype wire

// File: tb/tb_alu_operand_sequencer.sv
// ============================================================================
// Module : tb_alu_operand_sequencer
// Brief  : Directed self-checking bench for alu_operand_sequencer with a
//          behavioural 16-bit ALU attached.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_alu_operand_sequencer;

    logic        clk;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_op;
    logic [3:0]  req_rdest;
    logic [3:0]  req_rsrc;
    logic [7:0]  req_imm;
    logic        req_use_imm;
    logic        req_imm_signed;
    logic [15:0] alu_rsrc;
    logic [15:0] alu_rdest;
    logic [4:0]  alu_opcode;
    logic [15:0] alu_out;
    logic [4:0]  alu_flags;
    logic        done;
    logic        err;
    logic [4:0]  psr;
    logic [3:0]  dbg_addr;
    logic [15:0] dbg_data;

    int          n_total;
    int          n_pass;
    logic [15:0] last_alu_rsrc;
    logic [16:0] m_sum;

    alu_operand_sequencer u_dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_op         (req_op),
        .req_rdest      (req_rdest),
        .req_rsrc       (req_rsrc),
        .req_imm        (req_imm),
        .req_use_imm    (req_use_imm),
        .req_imm_signed (req_imm_signed),
        .alu_rsrc       (alu_rsrc),
        .alu_rdest      (alu_rdest),
        .alu_opcode     (alu_opcode),
        .alu_out        (alu_out),
        .alu_flags      (alu_flags),
        .done           (done),
        .err            (err),
        .psr            (psr),
        .dbg_addr       (dbg_addr),
        .dbg_data       (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU, flags {N,Z,F,L,C}; C/L on subtract mean unsigned borrow/less.
    always_comb begin
        m_sum     = '0;
        alu_out   = '0;
        alu_flags = '0;
        case (alu_opcode)
            5'd0: begin
                m_sum        = {1'b0, alu_rdest} + {1'b0, alu_rsrc};
                alu_out      = m_sum[15:0];
                alu_flags[0] = m_sum[16];
                alu_flags[2] = (alu_rdest[15] == alu_rsrc[15]) && (alu_out[15] != alu_rdest[15]);
            end
            5'd1, 5'd2: begin
                alu_out      = alu_rdest - alu_rsrc;
                alu_flags[0] = alu_rdest < alu_rsrc;
                alu_flags[1] = alu_rdest < alu_rsrc;
                alu_flags[2] = (alu_rdest[15] != alu_rsrc[15]) && (alu_out[15] != alu_rdest[15]);
            end
            5'd3: alu_out = alu_rdest & alu_rsrc;
            5'd4: alu_out = alu_rdest | alu_rsrc;
            5'd5: alu_out = alu_rdest ^ alu_rsrc;
            5'd6: alu_out = ~alu_rdest;
            5'd7: alu_out = alu_rdest << alu_rsrc[3:0];
            5'd8: alu_out = alu_rdest >> alu_rsrc[3:0];
            5'd9: alu_out = $signed(alu_rdest) >>> alu_rsrc[3:0];
            default: alu_out = 16'hDEAD;
        endcase
        alu_flags[3] = (alu_out == 16'h0000);
        alu_flags[4] = alu_out[15];
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reg(input string tag, input logic [3:0] idx, input logic [15:0] exp);
        dbg_addr = idx;
        #1;
        check(tag, dbg_data, exp);
    endtask

    // One instruction from an idle sequencer; returns one cycle after WB.
    task automatic issue(input logic [4:0] op, input logic [3:0] rd, input logic [3:0] rs,
                         input logic [7:0] imm, input logic ui, input logic sg);
        check("ready_idle", 16'(req_ready), 16'h1);
        req_valid      = 1'b1;
        req_op         = op;
        req_rdest      = rd;
        req_rsrc       = rs;
        req_imm        = imm;
        req_use_imm    = ui;
        req_imm_signed = sg;
        @(posedge clk); #1;
        req_valid     = 1'b0;
        last_alu_rsrc = alu_rsrc;
        check("exec_no_done", 16'(done), 16'h0);
        check("exec_opcode", 16'(alu_opcode), 16'(op));
        @(posedge clk); #1;
        check("wb_done", 16'(done), 16'h1);
        check("wb_err", 16'(err), 16'(op > 5'd9));
        @(posedge clk); #1;
        check("post_done_low", 16'(done), 16'h0);
    endtask

    initial begin
        int rdy_before;
        int idx;
        int n_done;
        int n_low;
        logic [4:0] b2b_op  [3];
        logic [7:0] b2b_imm [3];

        n_total = 0;
        n_pass  = 0;
        reset_n = 1'b0;
        req_valid = 1'b0;
        req_op = '0; req_rdest = '0; req_rsrc = '0; req_imm = '0;
        req_use_imm = 1'b0; req_imm_signed = 1'b0;
        dbg_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 16'(req_ready), 16'h1);
        check("rst_done", 16'(done), 16'h0);
        check("rst_err", 16'(err), 16'h0);
        check("rst_psr", 16'(psr), 16'h0);
        check("rst_alu_rsrc", alu_rsrc, 16'h0);
        check("rst_alu_opcode", 16'(alu_opcode), 16'h0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Preload r6 and PSR, then reset in the middle of EXEC.
        issue(5'd0, 4'd6, 4'd0, 8'hFF, 1'b1, 1'b1);
        check_reg("pre_r6", 4'd6, 16'hFFFF);
        check("pre_psr", 16'(psr), 16'h0010);
        req_valid = 1'b1; req_op = 5'd4; req_rdest = 4'd6; req_imm = 8'h01;
        req_use_imm = 1'b1; req_imm_signed = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("mid_exec_busy", 16'(req_ready), 16'h0);
        reset_n = 1'b0;
        #1;
        check("abort_ready", 16'(req_ready), 16'h1);
        check("abort_psr", 16'(psr), 16'h0);
        check_reg("abort_r6", 4'd6, 16'h0000);
        repeat (2) begin
            @(posedge clk); #1;
            check("abort_no_done", 16'(done), 16'h0);
        end
        for (int i = 0; i < 16; i++) begin
            check_reg("abort_reg_clear", 4'(i), 16'h0000);
        end
        reset_n = 1'b1;
        @(posedge clk); #1;

        // ADD overflow: r1=0x7FFF + r2=0x0001.
        issue(5'd4, 4'd1, 4'd0, 8'hFF, 1'b1, 1'b1);
        issue(5'd8, 4'd1, 4'd0, 8'h01, 1'b1, 1'b0);
        check_reg("r1_7fff", 4'd1, 16'h7FFF);
        issue(5'd4, 4'd2, 4'd0, 8'h01, 1'b1, 1'b0);
        issue(5'd0, 4'd1, 4'd2, 8'h00, 1'b0, 1'b0);
        check_reg("add_r1", 4'd1, 16'h8000);
        check("add_psr_F", 16'(psr[2]), 16'h1);
        check("add_psr_C", 16'(psr[0]), 16'h0);
        check("add_psr", 16'(psr), 16'h0014);

        // Aliased operands and arithmetic shift.
        issue(5'd0, 4'd2, 4'd2, 8'h00, 1'b0, 1'b0);
        check_reg("alias_r2", 4'd2, 16'h0002);
        check("alias_psr", 16'(psr), 16'h0000);
        issue(5'd9, 4'd1, 4'd0, 8'h0F, 1'b1, 1'b0);
        check_reg("arsh_r1", 4'd1, 16'hFFFF);

        // SUB with signed and unsigned immediate.
        issue(5'd4, 4'd3, 4'd0, 8'h05, 1'b1, 1'b0);
        issue(5'd1, 4'd3, 4'd0, 8'hFF, 1'b1, 1'b1);
        check("sub_s_alu_rsrc", last_alu_rsrc, 16'hFFFF);
        check_reg("sub_s_r3", 4'd3, 16'h0006);
        check("sub_s_psr", 16'(psr), 16'h0003);
        issue(5'd1, 4'd3, 4'd0, 8'hFF, 1'b1, 1'b0);
        check("sub_u_alu_rsrc", last_alu_rsrc, 16'h00FF);
        check_reg("sub_u_r3", 4'd3, 16'hFF07);

        // CMP equal then AND keeps PSR.
        issue(5'd4, 4'd4, 4'd0, 8'h03, 1'b1, 1'b0);
        issue(5'd4, 4'd5, 4'd0, 8'h03, 1'b1, 1'b0);
        issue(5'd2, 4'd4, 4'd5, 8'h00, 1'b0, 1'b0);
        check_reg("cmp_r4", 4'd4, 16'h0003);
        check("cmp_psr", 16'(psr), 16'h0008);
        issue(5'd3, 4'd4, 4'd5, 8'h00, 1'b0, 1'b0);
        check_reg("and_r4", 4'd4, 16'h0003);
        check("and_psr", 16'(psr), 16'h0008);

        // Illegal opcode is a no-op with err.
        issue(5'b11111, 4'd4, 4'd0, 8'h55, 1'b1, 1'b0);
        check_reg("ill_r4", 4'd4, 16'h0003);
        check("ill_psr", 16'(psr), 16'h0008);

        // Back-to-back with req_valid held: r7 = ((0+1)<<2)-1 = 3.
        b2b_op[0] = 5'd0; b2b_imm[0] = 8'h01;
        b2b_op[1] = 5'd7; b2b_imm[1] = 8'h02;
        b2b_op[2] = 5'd1; b2b_imm[2] = 8'h01;
        idx = 0; n_done = 0; n_low = 0;
        req_valid = 1'b1; req_rdest = 4'd7; req_rsrc = 4'd0;
        req_use_imm = 1'b1; req_imm_signed = 1'b0;
        req_op = b2b_op[0]; req_imm = b2b_imm[0];
        dbg_addr = 4'd7;
        for (int cyc = 0; cyc < 9; cyc++) begin
            rdy_before = int'(req_ready);
            @(posedge clk); #1;
            if (rdy_before != 0 && req_valid) begin
                idx++;
                if (idx < 3) begin
                    req_op  = b2b_op[idx];
                    req_imm = b2b_imm[idx];
                end else begin
                    req_valid = 1'b0;
                end
            end
            if (done) n_done++;
            if (!req_ready) n_low++;
        end
        check("b2b_accepts", 16'(idx), 16'd3);
        check("b2b_done_count", 16'(n_done), 16'd3);
        check("b2b_ready_low", 16'(n_low), 16'd6);
        check("b2b_r7", dbg_data, 16'h0003);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
